// File: rtl/life_frame_scheduler_pkg.sv
// life_pkg: shared grid sizing, cell-address type and scheduler enums.
package life_pkg;
  localparam int GRID_W = 80;
  localparam int GRID_H = 60;
  localparam int CELLS = GRID_W * GRID_H;
  localparam int ADDR_W = $clog2(CELLS);
  typedef logic [ADDR_W-1:0] cell_addr_t;
  typedef enum logic [1:0] {SEED, WAIT, RUN, SWAP} state_e;
  typedef enum logic [1:0] {NONE, VGA, ENG} owner_e;
endpackage

// File: rtl/life_frame_scheduler_if.sv
// life_frame_scheduler_if: all scheduler-facing signals; master is the scheduler side.
interface life_frame_scheduler_if
  import life_pkg::*;
();
  logic vsync_pulse, step_en, reseed, lfsr_bit, lfsr_adv;
  logic vga_req, vga_rvalid;
  cell_addr_t vga_addr;
  logic eng_start, eng_done, eng_req, eng_we, eng_wdata, eng_gnt, eng_rvalid;
  cell_addr_t eng_addr;
  logic mem_en, mem_we, mem_wdata, mem_rdata, rd_data;
  logic [ADDR_W:0] mem_addr;
  logic front_bank, busy;
  logic [15:0] gen_count;
  modport master (
    input vsync_pulse, step_en, reseed, lfsr_bit, vga_req, vga_addr, eng_done, eng_req,
          eng_we, eng_addr, eng_wdata, mem_rdata,
    output lfsr_adv, vga_rvalid, eng_start, eng_gnt, eng_rvalid, mem_en, mem_we, mem_addr,
           mem_wdata, rd_data, front_bank, gen_count, busy
  );
  modport slave (
    output vsync_pulse, step_en, reseed, lfsr_bit, vga_req, vga_addr, eng_done, eng_req,
           eng_we, eng_addr, eng_wdata, mem_rdata,
    input lfsr_adv, vga_rvalid, eng_start, eng_gnt, eng_rvalid, mem_en, mem_we, mem_addr,
          mem_wdata, rd_data, front_bank, gen_count, busy
  );
endinterface

// File: rtl/life_frame_scheduler_mem_arbiter.sv
// life_mem_arbiter: VGA-first arbitration of the single-port cell RAM with a fixed 2-cycle read return.
module life_mem_arbiter
  import life_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            vga_req_i,
  input  cell_addr_t      vga_addr_i,
  input  logic            eng_req_i,
  input  logic            eng_we_i,
  input  cell_addr_t      eng_addr_i,
  input  logic            eng_wdata_i,
  input  logic            run_i,
  input  logic            seed_i,
  input  cell_addr_t      seed_addr_i,
  input  logic            seed_bit_i,
  input  logic            front_bank_i,
  input  logic            mem_rdata_i,
  output logic            eng_gnt_o,
  output logic            seed_slot_o,
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [ADDR_W:0] mem_addr_o,
  output logic            mem_wdata_o,
  output logic            rd_data_o,
  output logic            vga_rvalid_o,
  output logic            eng_rvalid_o
);
  owner_e tag_q, tag_d;
  logic en_d, we_d, wdata_d;
  logic [ADDR_W:0] addr_d;
  assign eng_gnt_o = eng_req_i & ~vga_req_i & run_i;
  assign seed_slot_o = seed_i & ~vga_req_i;
  // engine writes always target the back bank; all reads come from the front bank
  always_comb begin
    en_d = vga_req_i | eng_gnt_o | seed_slot_o;
    we_d = eng_gnt_o ? eng_we_i : seed_slot_o;
    wdata_d = eng_gnt_o ? eng_we_i & eng_wdata_i : seed_slot_o & seed_bit_i;
    addr_d = vga_req_i ? {front_bank_i, vga_addr_i}
           : eng_gnt_o ? {front_bank_i ^ eng_we_i, eng_addr_i}
           : seed_slot_o ? {front_bank_i, seed_addr_i} : '0;
    tag_d = vga_req_i ? VGA : (eng_gnt_o & ~eng_we_i) ? ENG : NONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= 1'b0;
      tag_q <= NONE;
      rd_data_o <= 1'b0;
      vga_rvalid_o <= 1'b0;
      eng_rvalid_o <= 1'b0;
    end else begin
      mem_en_o <= en_d;
      mem_we_o <= we_d;
      mem_addr_o <= addr_d;
      mem_wdata_o <= wdata_d;
      tag_q <= tag_d;
      rd_data_o <= mem_rdata_i;
      vga_rvalid_o <= tag_q == VGA;
      eng_rvalid_o <= tag_q == ENG;
    end
  end
endmodule

// File: rtl/life_frame_scheduler.sv
// life_frame_scheduler: seeds the board, paces generations to vsync and swaps the display banks.
module life_frame_scheduler
  import life_pkg::*;
(
  input logic clk,
  input logic rst,
  life_frame_scheduler_if.master bus
);
  state_e state_q, state_d;
  cell_addr_t seed_cnt_q, seed_cnt_d;
  logic [15:0] gen_count_q, gen_count_d;
  logic front_bank_q, front_bank_d, pend_q, pend_d, start_q, start_d, adv_q, busy_q, seed_slot;
  life_mem_arbiter u_arb (
    .clk(clk), .rst(rst),
    .vga_req_i(bus.vga_req), .vga_addr_i(bus.vga_addr),
    .eng_req_i(bus.eng_req), .eng_we_i(bus.eng_we), .eng_addr_i(bus.eng_addr),
    .eng_wdata_i(bus.eng_wdata),
    .run_i(state_q == RUN), .seed_i(state_q == SEED), .seed_addr_i(seed_cnt_q),
    .seed_bit_i(bus.lfsr_bit), .front_bank_i(front_bank_q), .mem_rdata_i(bus.mem_rdata),
    .eng_gnt_o(bus.eng_gnt), .seed_slot_o(seed_slot),
    .mem_en_o(bus.mem_en), .mem_we_o(bus.mem_we), .mem_addr_o(bus.mem_addr),
    .mem_wdata_o(bus.mem_wdata), .rd_data_o(bus.rd_data),
    .vga_rvalid_o(bus.vga_rvalid), .eng_rvalid_o(bus.eng_rvalid)
  );
  always_comb begin
    state_d = state_q;
    seed_cnt_d = seed_cnt_q;
    gen_count_d = gen_count_q;
    front_bank_d = front_bank_q;
    pend_d = pend_q;
    start_d = 1'b0;
    case (state_q)
      SEED:
        if (bus.reseed) seed_cnt_d = '0;
        else if (seed_slot && seed_cnt_q == cell_addr_t'(CELLS - 1)) begin
          state_d = WAIT;
          seed_cnt_d = '0;
          gen_count_d = '0;
        end else if (seed_slot) seed_cnt_d = seed_cnt_q + 1'b1;
      WAIT:
        if (bus.reseed) state_d = SEED;
        else if (bus.vsync_pulse && bus.step_en) begin
          state_d = RUN;
          start_d = 1'b1;
        end
      RUN: begin
        pend_d = pend_q | bus.reseed;
        if (bus.eng_done) begin
          state_d = (pend_q | bus.reseed) ? SEED : SWAP;
          pend_d = 1'b0;
        end
      end
      SWAP:
        if (bus.reseed) state_d = SEED;
        else if (bus.vsync_pulse) begin
          front_bank_d = ~front_bank_q;
          gen_count_d = gen_count_q + 16'd1;
          state_d = bus.step_en ? RUN : WAIT;
          start_d = bus.step_en;
        end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
      seed_cnt_q <= '0;
      gen_count_q <= '0;
      front_bank_q <= 1'b0;
      pend_q <= 1'b0;
      start_q <= 1'b0;
      adv_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_cnt_q <= seed_cnt_d;
      gen_count_q <= gen_count_d;
      front_bank_q <= front_bank_d;
      pend_q <= pend_d;
      start_q <= start_d;
      adv_q <= seed_slot;
      busy_q <= state_d == SEED || state_d == RUN;
    end
  end
  assign bus.lfsr_adv = adv_q;
  assign bus.eng_start = start_q;
  assign bus.front_bank = front_bank_q;
  assign bus.gen_count = gen_count_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_life_frame_scheduler.sv
// tb_life_frame_scheduler: table-driven FSM vectors plus randomized arbitration against a reference model.
module tb_life_frame_scheduler;
  import life_pkg::*;
  logic clk, rst;
  int vectors = 0, miscompares = 0;
  logic mfb = 1'b0;
  logic ram [1 << (ADDR_W + 1)];
  logic shadow [1 << (ADDR_W + 1)];
  typedef struct {
    logic v; cell_addr_t va; logic e; logic w; cell_addr_t ea; logic d;
  } req_t;
  typedef struct {
    logic vs, st, rs, dn, fb, start, busy; logic [15:0] gen;
  } vec_t;
  req_t prev;
  vec_t tbl [11];
  life_frame_scheduler_if bus ();
  life_frame_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = bus.mem_en & ram[bus.mem_addr];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_cyc(input req_t r);
    logic [ADDR_W:0] ea;
    logic een, ewe;
    bus.vga_req = r.v; bus.vga_addr = r.va;
    bus.eng_req = r.e; bus.eng_we = r.w; bus.eng_addr = r.ea; bus.eng_wdata = r.d;
    #1 chk("eng_gnt", 32'(bus.eng_gnt), 32'(r.e & ~r.v));
    tick();
    een = r.v | r.e;
    ewe = ~r.v & r.e & r.w;
    ea = r.v ? {mfb, r.va} : r.e ? {mfb ^ r.w, r.ea} : '0;
    chk("mem_port", 32'({bus.mem_en, bus.mem_we, bus.mem_en ? bus.mem_addr : '0}), 32'({een, ewe, ea}));
    if (ewe) chk("mem_wdata", 32'(bus.mem_wdata), 32'(r.d));
    chk("vga_rvalid", 32'(bus.vga_rvalid), 32'(prev.v));
    chk("eng_rvalid", 32'(bus.eng_rvalid), 32'(prev.e & ~prev.v & ~prev.w));
    if (prev.v || (prev.e && !prev.w))
      chk("rd_data", 32'(bus.rd_data), 32'(shadow[{mfb, prev.v ? prev.va : prev.ea}]));
    if (ewe) shadow[{~mfb, r.ea}] = r.d;
    prev = r;
  endtask

  // seeding model: one write per free cycle at a counter that a reseed pulse rewinds
  task automatic do_seed(input int rs_at);
    int m = 0, k = 0, bad = 0;
    logic b, eb;
    while (m < CELLS && k < 20000) begin
      b = 1'($urandom);
      bus.lfsr_bit = b;
      bus.reseed = (k == rs_at);
      tick();
      eb = !(m == CELLS - 1 && k != rs_at);
      if (!(bus.mem_en && bus.mem_we && bus.mem_addr == (ADDR_W + 1)'(m) && bus.mem_wdata == b
            && bus.lfsr_adv && bus.busy == eb)) bad++;
      shadow[(ADDR_W + 1)'(m)] = b;
      m = (k == rs_at) ? 0 : m + 1;
      k++;
    end
    bus.reseed = 1'b0;
    chk("seed_write_errs", 32'(bad), 0);
    chk("seed_cycles", 32'(k), 32'(CELLS + (rs_at >= 0 ? rs_at + 1 : 0)));
    chk("seed_done_gen", 32'(bus.gen_count), 0);
    chk("seed_done_fb", 32'(bus.front_bank), 0);
    tick();
    chk("seed_idle", 32'({bus.mem_en, bus.lfsr_adv, bus.busy}), 0);
  endtask

  initial begin
    req_t r;
    rst = 1'b1;
    {bus.vsync_pulse, bus.step_en, bus.reseed, bus.lfsr_bit, bus.vga_req, bus.eng_done,
     bus.eng_req, bus.eng_we, bus.eng_wdata} = '0;
    bus.vga_addr = '0;
    bus.eng_addr = '0;
    prev = '{default: '0};
    tbl = '{
      '{0, 1, 0, 0, 0, 0, 0, 16'd0}, '{1, 1, 0, 0, 1, 1, 1, 16'd1}, '{0, 1, 0, 1, 1, 0, 0, 16'd1},
      '{1, 0, 0, 0, 0, 0, 0, 16'd2}, '{1, 0, 0, 0, 0, 0, 0, 16'd2}, '{1, 0, 0, 0, 0, 0, 0, 16'd2},
      '{1, 0, 0, 1, 0, 0, 0, 16'd2}, '{1, 1, 0, 0, 0, 1, 1, 16'd2}, '{1, 1, 0, 0, 0, 0, 1, 16'd2},
      '{0, 1, 1, 0, 0, 0, 1, 16'd2}, '{0, 1, 0, 1, 0, 0, 1, 16'd2}
    };
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({bus.lfsr_adv, bus.vga_rvalid, bus.eng_start, bus.eng_gnt, bus.eng_rvalid,
        bus.mem_en, bus.mem_we, bus.mem_wdata, bus.rd_data, bus.front_bank, bus.busy}), 0);
    chk("reset_addr", 32'(bus.mem_addr), 0);
    chk("reset_gen", 32'(bus.gen_count), 0);
    rst = 1'b0;
    do_seed(-1);
    bus.vsync_pulse = 1'b1; bus.step_en = 1'b1;
    tick();
    bus.vsync_pulse = 1'b0;
    chk("run_entry", 32'({bus.eng_start, bus.busy}), 32'b11);
    tick();
    chk("start_single", 32'(bus.eng_start), 0);
    for (int i = 0; i < 300; i++) begin
      r.v = ($urandom_range(0, 2) == 0);
      r.va = cell_addr_t'($urandom_range(0, CELLS - 1));
      r.e = 1'($urandom);
      r.w = 1'($urandom);
      r.ea = cell_addr_t'($urandom_range(0, CELLS - 1));
      r.d = 1'($urandom);
      run_cyc(r);
    end
    // VGA and engine contend for three cycles, then the engine gets through
    for (int i = 0; i < 4; i++) run_cyc('{i < 3, cell_addr_t'(10 + i), 1'b1, 1'b0, cell_addr_t'(42), 1'b0});
    run_cyc('{default: '0});
    run_cyc('{1'b0, '0, 1'b1, 1'b1, cell_addr_t'(5), 1'b1});
    chk("eng_write_addr5", 32'({bus.mem_we, bus.mem_addr}), 32'({1'b1, 14'h2005}));
    run_cyc('{default: '0});
    run_cyc('{default: '0});
    bus.eng_req = 1'b0;
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("swap_entry", 32'({bus.busy, bus.front_bank, bus.gen_count}), 0);
    for (int i = 0; i < 11; i++) begin
      bus.vsync_pulse = tbl[i].vs; bus.step_en = tbl[i].st;
      bus.reseed = tbl[i].rs; bus.eng_done = tbl[i].dn;
      tick();
      chk($sformatf("tbl%0d_fb_start_busy", i), 32'({bus.front_bank, bus.eng_start, bus.busy}),
          32'({tbl[i].fb, tbl[i].start, tbl[i].busy}));
      chk($sformatf("tbl%0d_gen", i), 32'(bus.gen_count), 32'(tbl[i].gen));
    end
    {bus.vsync_pulse, bus.reseed, bus.eng_done} = '0;
    do_seed(-1);
    bus.vsync_pulse = 1'b1; bus.step_en = 1'b1; bus.reseed = 1'b1;
    tick();
    {bus.vsync_pulse, bus.reseed} = '0;
    chk("reseed_beats_vsync", 32'({bus.eng_start, bus.busy}), 32'b01);
    do_seed(100);
    bus.vsync_pulse = 1'b1;
    tick();
    bus.vsync_pulse = 1'b0;
    chk("wrap_run", 32'({bus.eng_start, bus.busy}), 32'b11);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    force dut.gen_count_q = 16'hFFFF;
    tick();
    release dut.gen_count_q;
    tick();
    chk("wrap_pre", 32'(bus.gen_count), 32'hFFFF);
    bus.vsync_pulse = 1'b1; bus.step_en = 1'b0;
    tick();
    bus.vsync_pulse = 1'b0;
    chk("wrap_gen", 32'(bus.gen_count), 0);
    chk("wrap_fb_start_busy", 32'({bus.front_bank, bus.eng_start, bus.busy}), 32'b100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/life_frame_scheduler.md
Name: life_frame_scheduler

Overview:
- Sequences the Game-of-Life pipeline: LFSR seeding, per-frame generation updates and double-buffer swaps.
- Arbitrates one single-port cell memory between the VGA pixel fetcher, the update engine and the seeding writer.
- Sits between the LFSR, the life update engine, the cell RAM and the VGA timing/output path.
- VGA always wins the memory port; engine and seed traffic use the remaining cycles.

Parameters:
GRID_W, 80, cells per row (800 px / 10 px cells)
GRID_H, 60, cell rows (600 px / 10 px cells)
CELLS, GRID_W*GRID_H, cells per bank (localparam)
ADDR_W, $clog2(CELLS), cell address width (13 by default)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
vsync_pulse  in  1  one-cycle pulse at start of vertical blanking
step_en  in  1  1 = run, 0 = pause (hold current generation)
reseed  in  1  pulse, request a new LFSR seed
lfsr_bit  in  1  current LFSR output bit
lfsr_adv  out  1  pulse, LFSR bit consumed
vga_req  in  1  VGA cell read request
vga_addr  in  ADDR_W  VGA cell address (front bank)
vga_rvalid  out  1  VGA read data valid
eng_start  out  1  pulse, begin one generation
eng_done  in  1  pulse, engine finished generation
eng_req  in  1  engine memory request
eng_we  in  1  engine write (1) / read (0)
eng_addr  in  ADDR_W  engine cell address
eng_wdata  in  1  engine write data
eng_gnt  out  1  engine request accepted this cycle
eng_rvalid  out  1  engine read data valid
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W+1  {bank, cell address}
mem_wdata  out  1  RAM write data
rd_data  out  1  registered RAM read data (shared by both readers)
mem_rdata  in  1  RAM read data, 1-cycle latency after mem_en
front_bank  out  1  bank currently displayed
gen_count  out  16  generations completed, wraps 0xFFFF -> 0
busy  out  1  state is SEED or RUN

Behaviour:
- Reset: state = SEED, seed counter 0, front_bank 0, gen_count 0; every output 0.
- Grants (combinational):
  - vga_req always granted.
  - eng_gnt = eng_req & ~vga_req & (state == RUN).
  - Seed write slot = (state == SEED) & ~vga_req.
- Memory port (registered, one cycle after grant):
  - VGA read: addr {front_bank, vga_addr}.
  - Engine read: addr {front_bank, eng_addr}.
  - Engine write: addr {~front_bank, eng_addr}.
  - Seed write: addr {front_bank, seed_cnt}, wdata = lfsr_bit.
- Read return: a 2-bit owner tag travels with each read.
  - rd_data = registered mem_rdata.
  - vga_rvalid / eng_rvalid pulse exactly 2 cycles after the granted request.
  - Fixed 2-cycle latency regardless of contention once granted.
- An ungranted engine request must be held by the engine; the scheduler keeps no queue.
- FSM states:
  - SEED: each seed slot writes one cell, pulses lfsr_adv, increments seed_cnt. After cell CELLS-1 -> WAIT; gen_count cleared.
  - WAIT: on vsync_pulse & step_en -> RUN, pulsing eng_start in that cycle. step_en = 0 holds WAIT indefinitely.
  - RUN: engine traffic enabled. On eng_done -> SWAP.
  - SWAP: on vsync_pulse, toggle front_bank and increment gen_count. If step_en, go to RUN and pulse eng_start in the same cycle; otherwise go to WAIT.
- Swaps happen only on vsync_pulse, so the display never tears.
- Reseed:
  - Accepted in WAIT or SWAP: next state SEED, seed_cnt 0. Any pending swap is discarded, front_bank unchanged.
  - In RUN: latched as pending; honoured on eng_done instead of entering SWAP.
  - In SEED: restarts seeding at cell 0.
- Simultaneous vsync_pulse and reseed in WAIT/SWAP: reseed wins.
- eng_done outside RUN is ignored.
- VGA hogging every cycle stalls SEED and engine traffic indefinitely; there is no starvation guard, by design, because VGA blanking guarantees idle slots.
- rst asserted mid-operation aborts immediately. Memory contents are not cleared; SEED rewrites the front bank.

Decomposition:
- Package life_pkg:
  - State enum typedef {SEED, WAIT, RUN, SWAP}.
  - Owner tag enum typedef {NONE, VGA, ENG}.
  - GRID_W / GRID_H defaults and a cell-address typedef.
- Sub-module life_mem_arbiter: grant logic, registered memory port, owner-tag pipeline, rvalid generation.
- FSM, seed counter and gen_count stay in the top module.

Test Plan:
- Seed:
  - Stimulus: release reset, vga_req = 0, lfsr_bit toggling.
  - Response: 4800 writes to addresses 0..4799 with bank bit 0; 4800 lfsr_adv pulses; state WAIT after 4800 + 1 cycles; gen_count = 0.
- Priority:
  - Stimulus: in RUN, assert vga_req and eng_req together for 3 cycles, then drop vga_req.
  - Response: eng_gnt = 0 for those 3 cycles, then 1. vga_rvalid at cycles +2, +3, +4; eng_rvalid 2 cycles after its grant.
- Generation swap:
  - Stimulus: step_en = 1, vsync_pulse; engine writes addr 5 then eng_done; next vsync_pulse.
  - Response: write lands at mem_addr {1, 5}. front_bank goes 0 -> 1 on the vsync, gen_count = 1, eng_start pulses in the same cycle.
- Pause:
  - Stimulus: step_en = 0 across 3 vsync pulses in WAIT.
  - Response: no eng_start, front_bank and gen_count unchanged.
- Reseed mid-run:
  - Stimulus: reseed during RUN, then eng_done.
  - Response: state goes to SEED (not SWAP), front_bank unchanged, seed_cnt restarts at 0, gen_count = 0 when seeding completes.
- Wrap:
  - Stimulus: force gen_count = 0xFFFF, complete one swap.
  - Response: gen_count = 0x0000.
